// File: rtl/ppu_fetch_unit.sv
// ---------------------------------------------------------------------------
// ppu_fetch_unit
//
// Instruction fetch stage with a single branch delay slot. A PC/nPC pair
// advances in lock-step: the instruction after a taken branch (the delay
// slot) is always fetched before the target. A redirect that arrives while
// the PC is stalled is held in a pending register and applied on the next
// unstalled edge. The fetched word is latched into the IF/ID register
// together with its PC+8 link value.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   le_pc        in   PC/nPC load enable (0 = stall)
//   le_ifid      in   IF/ID register load enable
//   flush        in   load a NOP (all zero, invalid) into IF/ID
//   ta_valid     in   taken branch/jump reported by decode
//   target_addr  in   branch/jump target (low two bits ignored)
//   imem_rdata   in   instruction word at imem_addr (combinational memory)
//   imem_addr    out  fetch address, always equal to pc
//   pc           out  current PC
//   npc          out  next PC
//   if_id_instr  out  latched instruction word
//   if_id_pc8    out  PC+8 of the latched instruction (JAL link value)
//   if_id_valid  out  if_id_instr holds a fetched instruction
//   fetch_state  out  FSM state: BOOT=00, RUN=01, PEND=10
// ---------------------------------------------------------------------------
module ppu_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        le_pc,
    input  logic        le_ifid,
    input  logic        flush,
    input  logic        ta_valid,
    input  logic [31:0] target_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic [1:0]  fetch_state
);

    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PEND = 2'b10;

    logic [1:0]  state;
    logic [31:0] pending_target;
    logic [31:0] aligned_target;

    // Instructions are word aligned; the low two target bits are discarded.
    assign aligned_target = {target_addr[31:2], 2'b00};

    assign imem_addr   = pc;
    assign fetch_state = state;

    // PC/nPC pair, pending redirect and fetch state.
    // NOTE: every register here is updated with non-blocking assignments so
    // that pc picks up the *old* npc on the same edge npc takes its new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= 32'h0000_0000;
            npc            <= 32'h0000_0004;
            pending_target <= 32'h0000_0000;
            state          <= ST_BOOT;
        end else begin
            case (state)
                // One edge spent settling after reset; pc/npc do not move.
                ST_BOOT: state <= ST_RUN;

                ST_RUN: begin
                    if (le_pc) begin
                        pc  <= npc;
                        npc <= ta_valid ? aligned_target : npc + 32'd4;
                    end else if (ta_valid) begin
                        // Redirect arrived during a stall: remember it.
                        pending_target <= aligned_target;
                        state          <= ST_PEND;
                    end
                end

                // ta_valid is ignored here so the first captured target wins.
                ST_PEND: begin
                    if (le_pc) begin
                        pc    <= npc;
                        npc   <= pending_target;
                        state <= ST_RUN;
                    end
                end

                // Encoding 2'b11 is never produced; recover via BOOT.
                default: state <= ST_BOOT;
            endcase
        end
    end

    // IF/ID pipeline register. It loads independently of the PC so that a
    // fetched word may be dropped (le_pc=1, le_ifid=0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_instr <= 32'h0000_0000;
            if_id_pc8   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else if (state == ST_BOOT || flush) begin
            if_id_instr <= 32'h0000_0000;
            if_id_pc8   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else if (le_ifid) begin
            if_id_instr <= imem_rdata;
            if_id_pc8   <= pc + 32'd8;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ppu_fetch_unit
//
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the fetch rules (PC pair, pending redirect flag,
// IF/ID contents). Instruction memory is a fixed arithmetic function of the
// address so the expected fetched word can be recomputed from the model PC.
// ---------------------------------------------------------------------------
module tb_ppu_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        le_pc, le_ifid, flush, ta_valid;
    logic [31:0] target_addr;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr, pc, npc, if_id_instr, if_id_pc8;
    logic        if_id_valid;
    logic [1:0]  fetch_state;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_npc, m_target, m_instr, m_pc8;
    bit          m_valid, m_boot, m_pending;

    ppu_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .le_pc       (le_pc),
        .le_ifid     (le_ifid),
        .flush       (flush),
        .ta_valid    (ta_valid),
        .target_addr (target_addr),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .npc         (npc),
        .if_id_instr (if_id_instr),
        .if_id_pc8   (if_id_pc8),
        .if_id_valid (if_id_valid),
        .fetch_state (fetch_state)
    );

    always #5 clk = ~clk;

    // Memory contents: word at address 0 is 0x24010005.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h2401_0005;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic logic [1:0] m_state();
        if (m_boot)    return 2'b00;
        if (m_pending) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [162:0] observed();
        return {pc, npc, imem_addr, if_id_instr, if_id_pc8, if_id_valid, fetch_state};
    endfunction

    function automatic logic [162:0] expected();
        return {m_pc, m_npc, m_pc, m_instr, m_pc8, m_valid, m_state()};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_npc = 32'h4; m_target = 32'h0;
        m_instr = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
        m_boot = 1'b1; m_pending = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (m_boot) begin
            m_instr = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
            m_boot = 1'b0;
        end else begin
            if (m_pending) begin
                if (le_pc) begin
                    m_pc = m_npc; m_npc = m_target; m_pending = 1'b0;
                end
            end else if (le_pc) begin
                m_pc  = m_npc;
                m_npc = ta_valid ? (target_addr & ~32'h3) : m_npc + 32'd4;
            end else if (ta_valid) begin
                m_pending = 1'b1;
                m_target  = target_addr & ~32'h3;
            end
            if (flush) begin
                m_instr = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
            end else if (le_ifid) begin
                m_instr = mem_word(old_pc); m_pc8 = old_pc + 32'd8; m_valid = 1'b1;
            end
        end
    endtask

    // Called at a falling edge: run one rising edge, return at the next fall.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input bit lp, input bit li, input bit fl, input bit ta,
                          input logic [31:0] tgt);
        le_pc = lp; le_ifid = li; flush = fl; ta_valid = ta; target_addr = tgt;
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, 32'h0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (observed() !== {32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL reset_values got=%h exp=%h", observed(),
                     {32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_boot();
        set_in(1, 1, 0, 0, 32'h0);
        reset = 1'b1;
        tick();
        tests++;
        if (pc !== 32'h0 || if_id_valid !== 1'b0) begin
            fails++;
            $display("FAIL boot_edge1 got pc=%h valid=%b exp pc=0 valid=0", pc, if_id_valid);
        end
        tick();
        tests++;
        if ({pc, npc, if_id_instr, if_id_pc8} !== {32'h4, 32'h8, 32'h2401_0005, 32'h8}) begin
            fails++;
            $display("FAIL boot_edge2 got pc=%h npc=%h instr=%h pc8=%h exp 4 8 24010005 8",
                     pc, npc, if_id_instr, if_id_pc8);
        end
        tests++;
        if (observed() !== expected()) begin
            fails++;
            $display("FAIL boot_model got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_delay_slot();
        logic [31:0] seq [3];
        seq[0] = 32'h8; seq[1] = 32'h100; seq[2] = 32'h104;
        set_in(1, 1, 0, 1, 32'h0000_0103);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) ta_valid = 1'b0;
            tests++;
            if (pc !== seq[i]) begin
                fails++;
                $display("FAIL delay_slot_pc%0d got=%h exp=%h", i, pc, seq[i]);
            end
        end
        tests++;
        if (observed() !== expected()) begin
            fails++;
            $display("FAIL delay_slot_model got=%h exp=%h", observed(), expected());
        end
    endtask

    task automatic test_stalled_redirect();
        logic [31:0] old_pc, old_npc;
        old_pc = pc; old_npc = npc;
        set_in(0, 0, 0, 1, 32'h200);
        tick();
        tests++;
        if (fetch_state !== 2'b10 || pc !== old_pc || npc !== old_npc) begin
            fails++;
            $display("FAIL stall_capture got st=%b pc=%h npc=%h exp st=10 pc=%h npc=%h",
                     fetch_state, pc, npc, old_pc, old_npc);
        end
        set_in(0, 0, 0, 1, 32'h300);
        tick();
        tests++;
        if (fetch_state !== 2'b10 || pc !== old_pc || npc !== old_npc) begin
            fails++;
            $display("FAIL stall_hold got st=%b pc=%h npc=%h exp st=10 pc=%h npc=%h",
                     fetch_state, pc, npc, old_pc, old_npc);
        end
        set_in(1, 1, 0, 0, 32'h0);
        tick();
        tests++;
        if (pc !== old_npc || npc !== 32'h200 || fetch_state !== 2'b01) begin
            fails++;
            $display("FAIL stall_release got pc=%h npc=%h st=%b exp pc=%h npc=200 st=01",
                     pc, npc, fetch_state, old_npc);
        end
        tick();
        tests++;
        if (pc !== 32'h200) begin
            fails++;
            $display("FAIL stall_target got=%h exp=%h", pc, 32'h200);
        end
    endtask

    task automatic test_flush();
        logic [31:0] old_pc;
        old_pc = pc;
        set_in(1, 1, 1, 0, 32'h0);
        tick();
        tests++;
        if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || pc !== old_pc + 32'd4) begin
            fails++;
            $display("FAIL flush got instr=%h valid=%b pc=%h exp 0 0 %h",
                     if_id_instr, if_id_valid, pc, old_pc + 32'd4);
        end
        flush = 1'b0;
    endtask

    task automatic test_wrap();
        set_in(1, 1, 0, 1, 32'hFFFF_FFFC);
        tick();
        ta_valid = 1'b0;
        tick();
        tests++;
        if (pc !== 32'hFFFF_FFFC || npc !== 32'h0) begin
            fails++;
            $display("FAIL wrap_npc got pc=%h npc=%h exp fffffffc 0", pc, npc);
        end
        tick();
        tests++;
        if (if_id_pc8 !== 32'h4 || pc !== 32'h0 || npc !== 32'h4) begin
            fails++;
            $display("FAIL wrap_pc8 got pc8=%h pc=%h npc=%h exp 4 0 4", if_id_pc8, pc, npc);
        end
    endtask

    task automatic test_mid_reset();
        set_in(0, 1, 0, 1, 32'h500);
        tick();
        tests++;
        if (fetch_state !== 2'b10) begin
            fails++;
            $display("FAIL midreset_pend got=%b exp=10", fetch_state);
        end
        ta_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({pc, npc, fetch_state, if_id_valid} !== {32'h0, 32'h4, 2'b00, 1'b0}) begin
            fails++;
            $display("FAIL midreset_async got pc=%h npc=%h st=%b valid=%b exp 0 4 00 0",
                     pc, npc, fetch_state, if_id_valid);
        end
        @(negedge clk);
        set_in(1, 1, 0, 0, 32'h0);
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if (pc !== 32'h8 || npc !== 32'hC) begin
            fails++;
            $display("FAIL midreset_no_redirect got pc=%h npc=%h exp 8 c", pc, npc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8,
                   $urandom_range(9, 0) < 1, $urandom_range(3, 0) == 0, $urandom);
            tick();
            tests++;
            if (observed() !== expected()) begin
                fails++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_boot();
        test_delay_slot();
        test_stalled_redirect();
        test_flush();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppu_fetch_unit.md
PPU_FETCH_UNIT -- requirements
Module: ppu_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and reset.
REQ-002 The block SHALL provide these ports:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  le_pc  in  1  PC/nPC load enable; 0 = stall
  le_ifid  in  1  IF/ID register load enable
  flush  in  1  load NOP into IF/ID
  ta_valid  in  1  taken branch/jump from decode
  target_addr  in  32  branch/jump target
  imem_rdata  in  32  instruction word at imem_addr, combinational
  imem_addr  out  32  fetch address (equals pc)
  pc  out  32  current PC
  npc  out  32  next PC
  if_id_instr  out  32  instruction word presented to the control unit
  if_id_pc8  out  32  PC+8 of the latched instruction, JAL link value
  if_id_valid  out  1  if_id_instr holds a fetched instruction
  fetch_state  out  2  FSM state: BOOT=00, RUN=01, PEND=10

Function
REQ-003 The block SHALL implement a delay-slot fetch: pc <= npc and npc <= next value, on every rising edge where the state is RUN or PEND and le_pc=1.
REQ-004 In RUN with le_pc=1, the next npc SHALL be {target_addr[31:2],2'b00} when ta_valid=1, else npc+4.
REQ-005 All address arithmetic SHALL be modulo 2^32: npc=0xFFFFFFFC with no redirect SHALL give next npc=0x00000000, and if_id_pc8 SHALL wrap the same way.
REQ-006 imem_addr SHALL equal pc combinationally.
REQ-007 BOOT SHALL be entered on reset, SHALL hold pc/npc and load NOP into IF/ID, and SHALL go to RUN on the next edge regardless of the other inputs.
REQ-008 In RUN with le_pc=0 and ta_valid=1, the block SHALL capture {target_addr[31:2],2'b00} into an internal pending register, SHALL hold pc/npc, and SHALL go to PEND.
REQ-009 In RUN with le_pc=0 and ta_valid=0, the block SHALL hold pc, npc and the state.
REQ-010 In PEND, ta_valid SHALL be ignored, and the first captured target SHALL win.
REQ-011 In PEND with le_pc=0, the block SHALL hold everything.
REQ-012 In PEND with le_pc=1, the block SHALL set pc <= npc and npc <= pending target, then go to RUN.
REQ-013 Outside BOOT, the IF/ID register priority SHALL be flush, then le_ifid, then hold:
  flush=1: if_id_instr=0, if_id_pc8=0, if_id_valid=0
  le_ifid=1: if_id_instr=imem_rdata, if_id_pc8=pc+8, if_id_valid=1
  otherwise: hold all three
REQ-014 flush SHALL NOT affect pc, npc, the pending register or the state.
REQ-015 The IF/ID register and PC/nPC SHALL load independently, so that le_pc=1 with le_ifid=0 is legal and drops the fetched word.
REQ-016 State encoding 11 SHALL be unreachable and, if entered, SHALL return to BOOT on the next edge.

Reset
REQ-017 While reset=0, the block SHALL asynchronously force all of the following, and the pending register SHALL clear to 0:
  pc=0x00000000
  npc=0x00000004
  if_id_instr=0
  if_id_pc8=0
  if_id_valid=0
  fetch_state=BOOT
REQ-018 Reset asserted mid-operation, including in PEND, SHALL discard any pending redirect.
REQ-019 After reset release, the first pc advance SHALL occur on the second rising edge, the first edge being spent in BOOT.

Verification
REQ-020 Boot: release reset with le_pc=le_ifid=1, imem_rdata=0x24010005 at address 0.
  Edge 1: BOOT, pc=0, if_id_valid=0.
  Edge 2: pc=4, npc=8, if_id_instr=0x24010005, if_id_pc8=8.
REQ-021 Delay slot: in RUN at pc=4, npc=8, pulse ta_valid with target_addr=0x00000103.
  The following pc sequence SHALL be 8, then 0x100, then 0x104.
REQ-022 Stalled redirect: in RUN, le_pc=0 with ta_valid=1 and target 0x200.
  Required: fetch_state=PEND and pc/npc held.
  Then ta_valid=1 with target 0x300 while stalled: ignored.
  Then le_pc=1: pc=old npc, then 0x200.
REQ-023 Flush: flush=1 and le_ifid=1 on the same edge.
  Required: if_id_instr=0, if_id_valid=0, and pc still advances by 4.
REQ-024 Wrap: drive npc to 0xFFFFFFFC via target_addr=0xFFFFFFFC.
  Required: next npc=0x00000000, and if_id_pc8 for pc=0xFFFFFFFC equals 0x00000004.
REQ-025 Mid-run reset: assert reset asynchronously between edges while in PEND.
  Required: immediately pc=0, npc=4, fetch_state=BOOT, if_id_valid=0.
  After release: no redirect to the old pending target.
